// File: rtl/graph_capture_pkg.sv
// Shared types and constants for the result-vector change capture block.
// The event word layout is {timestamp, value}, with the value in the low bits.
package graph_capture_pkg;

    localparam int VAL_W     = 4;
    localparam int TS_W_DEF  = 8;
    localparam int DEPTH_DEF = 8;

    typedef struct packed {
        logic [TS_W_DEF-1:0] ts;
        logic [VAL_W-1:0]    val;
    } event_t;

    // Occupancy counter width: must be able to hold DEPTH itself.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/graph_sync_fifo.sv
// Synchronous FIFO with valid/ready drain and an occupancy count.
// There is no fall-through: a write is visible at the head one cycle later.
module graph_sync_fifo
    import graph_capture_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [WIDTH-1:0]          push_data,
    output logic                      push_drop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [level_w(DEPTH)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LW    = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LW-1:0]    cnt;
    logic             full;
    logic             empty;
    logic             pop;
    logic             wr_en;

    assign full  = (cnt == LW'(DEPTH));
    assign empty = (cnt == '0);
    assign pop   = ~empty & out_ready;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign wr_en     = push & (~full | pop);
    assign push_drop = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : mem[rd_ptr];
    assign level     = cnt;

endmodule

// File: rtl/graph_result_capture.sv
// Watches the registered result vector, logs each change as {ts, value}
// into a small FIFO, and flags (sticky) any event lost to a full FIFO.
module graph_result_capture
    import graph_capture_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [VAL_W-1:0]          q_in,
    input  logic                      clr_ovf,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TS_W+VAL_W-1:0]     out_data,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      overflow
);

    logic [TS_W-1:0]       ts;
    logic [VAL_W-1:0]      prev;
    logic                  armed;
    logic                  push_req;
    logic                  push_drop;
    logic [TS_W+VAL_W-1:0] push_word;

    // A disarmed capture always logs the first enabled sample as a baseline.
    assign push_req  = en & (~armed | (q_in != prev));
    assign push_word = {ts, q_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts    <= '0;
            prev  <= '0;
            armed <= 1'b0;
        end else if (en) begin
            ts    <= ts + 1'b1;
            prev  <= q_in;
            armed <= 1'b1;
        end else begin
            armed <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    graph_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W + VAL_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (push_word),
        .push_drop (push_drop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

endmodule
